// File: rtl/cpu_dbg_pkg.sv
// Shared debug-path types and sizes for the regfile,
// the core operand-read mux and the dump reader.
package cpu_dbg_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    READ,
    SEND
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks a register range through the borrowed regfile
// read port and streams (addr, data) beats out.
module regfile_dump
  import cpu_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  dump_state_t       state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_r;
  logic [ADDR_W-1:0] nxt;

  // address wraps naturally at NUM_REGS
  assign nxt = cur + ADDR_W'(1);

  // dump FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      end_r     <= '0;
      rd_addr   <= '0;
      rd_req    <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur     <= first_addr;
            end_r   <= last_addr;
            rd_addr <= first_addr;
            rd_req  <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (rd_gnt) begin
            state <= READ;
          end
        end
        READ: begin
          if (rd_gnt) begin
            out_data  <= rd_data;
            out_addr  <= cur;
            out_valid <= 1'b1;
            rd_req    <= 1'b0;
            state     <= SEND;
          end else begin
            state <= REQ;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (cur == end_r) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              rd_addr <= '0;
              state   <= IDLE;
            end else begin
              cur     <= nxt;
              rd_addr <= nxt;
              rd_req  <= 1'b1;
              state   <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a
// behavioural combinational regfile beside it.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] regs [16];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  regfile_dump dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .first_addr(first_addr),
    .last_addr(last_addr),
    .rd_req(rd_req),
    .rd_gnt(rd_gnt),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_data(out_data),
    .busy(busy),
    .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // waits for a beat and returns once its
  // handshake edge has passed
  task automatic beat(input string tag,
                      input logic [3:0] ea,
                      input logic [31:0] ed);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid && out_ready) begin
        chk({tag, "_addr"}, 32'(out_addr), 32'(ea));
        chk({tag, "_data"}, out_data, ed);
        got = 1'b1;
      end
      tick();
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=none expected=beat",
             tag);
    end
  endtask

  task automatic go(input logic [3:0] f,
                    input logic [3:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int t0;
    int d0;
    rst_n      = 1'b0;
    start      = 1'b0;
    first_addr = 4'd0;
    last_addr  = 4'd0;
    rd_gnt     = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 32'(i * 3);
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(rd_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_raddr", 32'(rd_addr), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // full dump 0..15, grant and ready tied high
    rd_gnt    = 1'b1;
    out_ready = 1'b1;
    go(4'd0, 4'd15);
    t0 = cyc;
    chk("lat_v0", 32'(out_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_req", 32'(rd_req), 32'd1);
    tick();
    chk("lat_v1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_v2", 32'(out_valid), 32'd1);
    for (int k = 0; k < 16; k++)
      beat("full", 4'(k), 32'(k * 3));
    chk("full_cycles", 32'(cyc - t0), 32'd48);
    chk("full_done", 32'(done), 32'd1);
    chk("full_busy", 32'(busy), 32'd0);
    tick();
    chk("full_done_pulse", 32'(done), 32'd0);
    chk("full_done_cnt", 32'(done_cnt), 32'd1);

    // wrap-around 14..1
    for (int i = 0; i < 16; i++)
      regs[i] = 32'hA000_0000 + 32'(i);
    go(4'd14, 4'd1);
    beat("wrap0", 4'd14, 32'hA000_000E);
    beat("wrap1", 4'd15, 32'hA000_000F);
    beat("wrap2", 4'd0, 32'hA000_0000);
    beat("wrap3", 4'd1, 32'hA000_0001);
    chk("wrap_done", 32'(done), 32'd1);
    tick();

    // backpressure on a single-register dump
    regs[5]   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    go(4'd5, 4'd5);
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_addr", 32'(out_addr), 32'd5);
      chk("bp_data", out_data, 32'hDEAD_BEEF);
      tick();
    end
    out_ready = 1'b1;
    d0 = done_cnt;
    tick();
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_valid_off", 32'(out_valid), 32'd0);
    tick();
    chk("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
    regs[5] = 32'hA000_0005;

    // grant loss in REQ and in READ
    rd_gnt = 1'b0;
    go(4'd2, 4'd3);
    for (int i = 0; i < 4; i++) begin
      chk("gl_req", 32'(rd_req), 32'd1);
      chk("gl_raddr", 32'(rd_addr), 32'd2);
      chk("gl_valid", 32'(out_valid), 32'd0);
      tick();
    end
    rd_gnt = 1'b1;
    tick();
    rd_gnt = 1'b0;
    tick();
    chk("gl_nocap", 32'(out_valid), 32'd0);
    chk("gl_req2", 32'(rd_req), 32'd1);
    tick();
    chk("gl_nocap2", 32'(out_valid), 32'd0);
    rd_gnt = 1'b1;
    beat("gl0", 4'd2, 32'hA000_0002);
    beat("gl1", 4'd3, 32'hA000_0003);
    chk("gl_done", 32'(done), 32'd1);
    tick();

    // start while busy is ignored, start on done accepted
    go(4'd0, 4'd3);
    beat("sb0", 4'd0, 32'hA000_0000);
    go(4'd9, 4'd9);
    beat("sb1", 4'd1, 32'hA000_0001);
    beat("sb2", 4'd2, 32'hA000_0002);
    beat("sb3", 4'd3, 32'hA000_0003);
    chk("sb_done", 32'(done), 32'd1);
    go(4'd9, 4'd9);
    chk("sb_restart_busy", 32'(busy), 32'd1);
    chk("sb_restart_raddr", 32'(rd_addr), 32'd9);
    beat("sb9", 4'd9, 32'hA000_0009);
    chk("sb9_done", 32'(done), 32'd1);
    tick();

    // async reset while beat 2 sits in SEND
    go(4'd0, 4'd3);
    beat("ar0", 4'd0, 32'hA000_0000);
    out_ready = 1'b0;
    tick();
    tick();
    chk("ar_hold_valid", 32'(out_valid), 32'd1);
    chk("ar_hold_addr", 32'(out_addr), 32'd1);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_req", 32'(rd_req), 32'd0);
    chk("ar_addr", 32'(out_addr), 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_raddr", 32'(rd_addr), 32'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("ar_no_done", 32'(done_cnt - d0), 32'd0);
    tick();
    go(4'd7, 4'd7);
    beat("ar7", 4'd7, 32'hA000_0007);
    chk("ar7_done", 32'(done), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
